// File: rtl/bin2bcd_display_conv.sv
// Sequential binary-to-packed-BCD converter (double dabble, one bit per clock)
// feeding the 4-digit seven-segment driver; holds the last result between conversions.
module bin2bcd_display_conv #(
  parameter int          BIN_W       = 16,
  parameter logic [15:0] OVF_PATTERN = 16'hEEEE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [BIN_W-1:0] bin_in,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output logic [15:0]      bcd_out
);

  // state | meaning
  // IDLE  | waiting for start; result registers hold last value
  // SHIFT | one add-3/shift iteration per clock, BIN_W iterations
  // LOAD  | publish result or overflow pattern, pulse done
  typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

  localparam int SCR_W = 20 + BIN_W;

  state_t           state, state_nxt;
  logic [SCR_W-1:0] scratch, scratch_adj;
  logic [4:0]       cnt;
  logic             last_shift;

  assign last_shift = (cnt == 5'(BIN_W - 1));

  // Pre-shift correction on all five BCD digits.
  always_comb begin
    scratch_adj = scratch;
    for (int d = 0; d < 5; d++) begin
      if (scratch[BIN_W + 4*d +: 4] >= 4'd5)
        scratch_adj[BIN_W + 4*d +: 4] = scratch[BIN_W + 4*d +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (last_shift) state_nxt = LOAD;
      LOAD:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scratch  <= '0;
      cnt      <= '0;
      done     <= 1'b0;
      overflow <= 1'b0;
      bcd_out  <= 16'h0000;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            scratch <= {20'd0, bin_in};
            cnt     <= '0;
          end
        end
        SHIFT: begin
          scratch <= {scratch_adj[SCR_W-2:0], 1'b0};
          cnt     <= cnt + 5'd1;
        end
        LOAD: begin
          done <= 1'b1;
          if (scratch[SCR_W-1 -: 4] != 4'd0) begin
            bcd_out  <= OVF_PATTERN;
            overflow <= 1'b1;
          end else begin
            bcd_out  <= scratch[BIN_W +: 16];
            overflow <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_display_conv.sv
// Self-checking bench for bin2bcd_display_conv: vector table, corner sequences,
// and random values against an arithmetic decimal model.
module tb_bin2bcd_display_conv;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] bin_in = 16'd0;
  logic        busy, done, overflow;
  logic [15:0] bcd_out;

  int n_total = 0;
  int n_pass  = 0;

  bin2bcd_display_conv #(.BIN_W(16), .OVF_PATTERN(16'hEEEE)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bin_in(bin_in),
    .busy(busy), .done(done), .overflow(overflow), .bcd_out(bcd_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] bin;
    logic [15:0] bcd;
    logic        ovf;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference: decimal digits by division, overflow pattern above 9999.
  function automatic logic [16:0] ref_conv(input int v);
    logic [15:0] r;
    if (v > 9999) return {1'b1, 16'hEEEE};
    r = {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    return {1'b0, r};
  endfunction

  // Starts a conversion from IDLE; returns edges from accept to done (-1 on timeout)
  // and number of post-edge samples with busy high before done.
  task automatic convert(input logic [15:0] v, output int lat, output int bsy);
    @(negedge clk);
    bin_in = v;
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    bin_in = 16'($urandom);
    bsy = busy ? 1 : 0;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (done) begin lat = k; break; end
      if (busy) bsy++;
    end
  endtask

  initial begin
    vec_t        tbl[7];
    int          lat, bsy, dcnt, saw;
    int          dq[$];
    logic [16:0] r;
    int          v;

    tbl[0] = '{16'd0,     16'h0000, 1'b0};
    tbl[1] = '{16'd9,     16'h0009, 1'b0};
    tbl[2] = '{16'd10,    16'h0010, 1'b0};
    tbl[3] = '{16'd9999,  16'h9999, 1'b0};
    tbl[4] = '{16'd10000, 16'hEEEE, 1'b1};
    tbl[5] = '{16'd65535, 16'hEEEE, 1'b1};
    tbl[6] = '{16'd42,    16'h0042, 1'b0};

    // Reset state
    #23;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_bcd", 32'(bcd_out), 32'h0000);
    @(negedge clk); rst_n = 1'b1;
    dcnt = 0;
    repeat (10) begin @(posedge clk); #1; if (done) dcnt++; end
    chk("no_done_after_rst", 32'(dcnt), 0);

    // 1234: latency, busy window, done pulse width, hold
    convert(16'd1234, lat, bsy);
    chk("lat_1234", 32'(lat), 17);
    chk("busy_cycles_1234", 32'(bsy), 17);
    chk("busy_at_done", 32'(busy), 0);
    chk("bcd_1234", 32'(bcd_out), 32'h1234);
    @(posedge clk); #1;
    chk("done_drop", 32'(done), 0);
    repeat (5) @(posedge clk); #1;
    chk("hold_1234", 32'(bcd_out), 32'h1234);

    // Boundary table
    for (int i = 0; i < 7; i++) begin
      convert(tbl[i].bin, lat, bsy);
      chk($sformatf("tbl_lat_%0d", tbl[i].bin), 32'(lat), 17);
      chk($sformatf("tbl_bcd_%0d", tbl[i].bin), 32'(bcd_out), 32'(tbl[i].bcd));
      chk($sformatf("tbl_ovf_%0d", tbl[i].bin), 32'(overflow), 32'(tbl[i].ovf));
    end

    // Start while busy is ignored
    @(negedge clk); bin_in = 16'd500; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk); bin_in = 16'd777; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    dcnt = 0; saw = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) dcnt++;
      if (bcd_out == 16'h0777) saw = 1;
    end
    chk("busy_start_done_cnt", 32'(dcnt), 1);
    chk("busy_start_no_777", 32'(saw), 0);
    chk("busy_start_bcd", 32'(bcd_out), 32'h0500);

    // Start held high: one conversion every 18 cycles
    @(negedge clk); bin_in = 16'd321; start = 1'b1;
    saw = 0;
    for (int k = 1; k <= 80; k++) begin
      @(posedge clk); #1;
      if (done) dq.push_back(k);
      if (dq.size() > 0 && bcd_out != 16'h0321) saw = 1;
    end
    @(negedge clk); start = 1'b0;
    chk("held_done_cnt", 32'(dq.size()), 4);
    if (dq.size() > 0) chk("held_first_done", 32'(dq[0]), 18);
    for (int i = 1; i < dq.size(); i++) chk($sformatf("held_spacing_%0d", i), 32'(dq[i] - dq[i-1]), 18);
    chk("held_bcd_stable", 32'(saw), 0);
    repeat (20) @(posedge clk);

    // Reset mid-conversion
    @(negedge clk); bin_in = 16'd4321; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (7) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_done", 32'(done), 0);
    chk("midrst_ovf", 32'(overflow), 0);
    chk("midrst_bcd", 32'(bcd_out), 32'h0000);
    @(negedge clk); rst_n = 1'b1;
    dcnt = 0;
    repeat (25) begin @(posedge clk); #1; if (done) dcnt++; end
    chk("midrst_no_done", 32'(dcnt), 0);
    convert(16'd55, lat, bsy);
    chk("post_rst_lat", 32'(lat), 17);
    chk("post_rst_bcd", 32'(bcd_out), 32'h0055);

    // Random values against the decimal model
    for (int i = 0; i < 40; i++) begin
      v = (i % 2 == 0) ? int'($urandom_range(0, 9999)) : int'($urandom_range(0, 65535));
      r = ref_conv(v);
      convert(16'(v), lat, bsy);
      chk($sformatf("rnd_lat_%0d", v), 32'(lat), 17);
      chk($sformatf("rnd_bcd_%0d", v), 32'(bcd_out), 32'(r[15:0]));
      chk($sformatf("rnd_ovf_%0d", v), 32'(overflow), 32'(r[16]));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
